lcd_cfah_ctrl: RTL and testbench



---
 rtl/lcd_cfah_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_lcd_cfah_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cfah_ctrl.sv
// Single-byte transaction sequencer for a CFAH (HD44780-compatible) character LCD.
// It generates the rs/rw/en/data bus timing and polls the busy flag after every access.
module lcd_cfah_ctrl #(
  parameter int G_SETUP_CYCLES   = 2,
  parameter int G_EN_HIGH_CYCLES = 12,
  parameter int G_HOLD_CYCLES    = 2,
  parameter int G_BF_GAP_CYCLES  = 4,
  parameter int G_BF_MAX_POLLS   = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_rs,
  input  logic       i_rnw,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_rdata,
  output logic       o_done,
  output logic       o_busy,
  output logic       o_timeout,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  inout  wire  [7:0] io_lcd_data,
  output logic       o_lcd_on
);

  localparam int T_MAX_A = (G_SETUP_CYCLES > G_EN_HIGH_CYCLES) ? G_SETUP_CYCLES : G_EN_HIGH_CYCLES;
  localparam int T_MAX_B = (G_HOLD_CYCLES > G_BF_GAP_CYCLES) ? G_HOLD_CYCLES : G_BF_GAP_CYCLES;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int CW      = $clog2(T_MAX) + 1;
  localparam int PW      = (G_BF_MAX_POLLS > 0) ? $clog2(G_BF_MAX_POLLS + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETUP,
    S_EN_HI,
    S_HOLD,
    S_BF_SETUP,
    S_BF_EN_HI,
    S_BF_HOLD,
    S_BF_GAP,
    S_DONE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic            cnt_zero;
  logic [PW-1:0]   poll_q;
  logic            poll_at_max;
  logic            rs_q;
  logic            rnw_q;
  logic [7:0]      wdata_q;
  logic            busy_flag_q;
  logic [7:0]      rdata_q;
  logic            timeout_q;
  logic            lcd_on_q;
  logic            drive;

  // Dwell time of each timed state, minus one, loaded on entry.
  function automatic logic [CW-1:0] dwell(input state_t s);
    case (s)
      S_SETUP, S_BF_SETUP: return CW'(G_SETUP_CYCLES - 1);
      S_EN_HI, S_BF_EN_HI: return CW'(G_EN_HIGH_CYCLES - 1);
      S_HOLD,  S_BF_HOLD:  return CW'(G_HOLD_CYCLES - 1);
      S_BF_GAP:            return CW'(G_BF_GAP_CYCLES - 1);
      default:             return '0;
    endcase
  endfunction

  assign cnt_zero    = (cnt_q == '0);
  assign poll_at_max = (poll_q == PW'(G_BF_MAX_POLLS));

  // NOTE: non-blocking assignments in clocked blocks, so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (i_start)  state_d = S_SETUP;
      S_SETUP:    if (cnt_zero) state_d = S_EN_HI;
      S_EN_HI:    if (cnt_zero) state_d = S_HOLD;
      S_HOLD:     if (cnt_zero) state_d = (G_BF_MAX_POLLS == 0) ? S_DONE : S_BF_SETUP;
      S_BF_SETUP: if (cnt_zero) state_d = S_BF_EN_HI;
      S_BF_EN_HI: if (cnt_zero) state_d = S_BF_HOLD;
      S_BF_HOLD:  if (cnt_zero) state_d = (busy_flag_q && !poll_at_max) ? S_BF_GAP : S_DONE;
      S_BF_GAP:   if (cnt_zero) state_d = S_BF_SETUP;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // NOTE: the latched payload is reset as well, so no unknown value can ever reach the LCD pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      poll_q      <= '0;
      rs_q        <= 1'b0;
      rnw_q       <= 1'b1;
      wdata_q     <= 8'h00;
      busy_flag_q <= 1'b0;
      rdata_q     <= 8'h00;
      timeout_q   <= 1'b0;
      lcd_on_q    <= 1'b0;
    end else begin
      lcd_on_q <= 1'b1;

      if (state_d != state_q) begin
        cnt_q <= dwell(state_d);
      end else if (!cnt_zero) begin
        cnt_q <= cnt_q - CW'(1);
      end

      if (state_q == S_IDLE && i_start) begin
        rs_q      <= i_rs;
        rnw_q     <= i_rnw;
        wdata_q   <= i_wdata;
        timeout_q <= 1'b0;
      end

      // Both LCD read captures happen on the last cycle en is high, when the bus has settled longest.
      if (state_q == S_EN_HI && cnt_zero && rnw_q) begin
        rdata_q <= io_lcd_data;
      end
      if (state_q == S_BF_EN_HI && cnt_zero) begin
        busy_flag_q <= io_lcd_data[7];
      end

      if (state_q == S_HOLD && state_d == S_BF_SETUP) begin
        poll_q <= PW'(1);
      end else if (state_q == S_BF_GAP && state_d == S_BF_SETUP) begin
        poll_q <= poll_q + PW'(1);
      end

      if (state_q == S_BF_HOLD && cnt_zero && busy_flag_q && poll_at_max) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // NOTE: every output gets a default before the case, so no path through it infers a latch.
  always_comb begin
    o_lcd_rs = 1'b0;
    o_lcd_rw = 1'b1;
    o_lcd_en = 1'b0;
    drive    = 1'b0;
    o_done   = 1'b0;
    o_busy   = 1'b1;
    unique case (state_q)
      S_IDLE: o_busy = 1'b0;
      S_SETUP, S_HOLD: begin
        o_lcd_rs = rs_q;
        o_lcd_rw = rnw_q;
        drive    = !rnw_q;
      end
      S_EN_HI: begin
        o_lcd_rs = rs_q;
        o_lcd_rw = rnw_q;
        o_lcd_en = 1'b1;
        drive    = !rnw_q;
      end
      S_BF_EN_HI: o_lcd_en = 1'b1;
      S_DONE:     o_done   = 1'b1;
      default: ;
    endcase
  end

  // The bus is only ever driven while rw is low, so the LCD and this block never fight.
  assign io_lcd_data = drive ? wdata_q : 8'hzz;
  assign o_rdata     = rdata_q;
  assign o_timeout   = timeout_q;
  assign o_lcd_on    = lcd_on_q;

endmodule

// File: tb/tb_lcd_cfah_ctrl.sv
// Self-checking bench for lcd_cfah_ctrl: table-driven transactions against an LCD emulator,
// plus back-to-back start and mid-transaction reset sequences.
module tb_lcd_cfah_ctrl;

  localparam int MAX_POLLS = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_rs = 1'b0;
  logic       i_rnw = 1'b0;
  logic [7:0] i_wdata = 8'h00;
  logic [7:0] o_rdata;
  logic       o_done;
  logic       o_busy;
  logic       o_timeout;
  logic       o_lcd_rs;
  logic       o_lcd_rw;
  logic       o_lcd_en;
  logic       o_lcd_on;
  wire  [7:0] lcd_data;

  int n_vec = 0;
  int n_bad = 0;

  // LCD emulator: answers reads while en is high; busy for the first emu_busy_polls flag reads.
  int         polls_done = 0;
  int         emu_busy_polls = 0;
  logic [7:0] emu_rdata = 8'h00;
  logic [7:0] emu_val;

  always_comb emu_val = o_lcd_rs ? emu_rdata : {(polls_done < emu_busy_polls), 7'h00};
  assign lcd_data = (o_lcd_rw && o_lcd_en) ? emu_val : 8'hzz;

  lcd_cfah_ctrl #(
    .G_SETUP_CYCLES  (2),
    .G_EN_HIGH_CYCLES(12),
    .G_HOLD_CYCLES   (2),
    .G_BF_GAP_CYCLES (4),
    .G_BF_MAX_POLLS  (MAX_POLLS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_rs       (i_rs),
    .i_rnw      (i_rnw),
    .i_wdata    (i_wdata),
    .o_rdata    (o_rdata),
    .o_done     (o_done),
    .o_busy     (o_busy),
    .o_timeout  (o_timeout),
    .o_lcd_rs   (o_lcd_rs),
    .o_lcd_rw   (o_lcd_rw),
    .o_lcd_en   (o_lcd_en),
    .io_lcd_data(lcd_data),
    .o_lcd_on   (o_lcd_on)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic       rnw;
    logic [7:0] wdata;
    int         busy_polls;
    logic [7:0] emu_rdata;
    int         exp_lat;
    int         exp_pulses;
    logic       exp_timeout;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[4];
  vec_t sb[$];
  int   done_at[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected en at sample s (s=0 is the first cycle after the accepting edge): one 12-cycle
  // access pulse after 2 setup cycles, then poll pulses every 2+12+2+4 = 20 cycles from s=16.
  function automatic bit exp_en(input int s, input int polls);
    int r;
    if (s >= 2 && s < 14) return 1'b1;
    if (s < 16) return 1'b0;
    r = s - 16;
    for (int p = 0; p < polls; p++) begin
      if (r >= p * 20 + 2 && r < p * 20 + 14) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic run_txn(input vec_t v);
    int   s;
    int   pulses;
    int   run;
    int   bad_en;
    int   bad_len;
    int   bad_bus;
    bit   en_prev;
    bit   seen_done;
    vec_t e;

    @(negedge clk);
    check("idle_before_start", o_busy, 1'b0);
    i_rs           = v.rs;
    i_rnw          = v.rnw;
    i_wdata        = v.wdata;
    emu_rdata      = v.emu_rdata;
    emu_busy_polls = v.busy_polls;
    polls_done     = 0;
    i_start        = 1'b1;
    sb.push_back(v);
    @(posedge clk);

    s = 0; pulses = 0; run = 0; bad_en = 0; bad_len = 0; bad_bus = 0;
    en_prev = 1'b0; seen_done = 1'b0;
    while (s < 400 && !seen_done) begin
      @(negedge clk);
      // Scramble the request inputs: the transaction must run from the latched copy.
      i_start = 1'b0;
      i_rs    = ~v.rs;
      i_rnw   = ~v.rnw;
      i_wdata = ~v.wdata;
      if (o_lcd_en !== exp_en(s, v.exp_pulses - 1)) bad_en++;
      if (o_lcd_en && !en_prev) pulses++;
      if (!o_lcd_en && en_prev) begin
        if (run != 12) bad_len++;
        run = 0;
        if (s > 16) polls_done++;
      end
      if (o_lcd_en) run++;
      en_prev = o_lcd_en;
      if (s < 16) begin
        if (o_lcd_rs !== v.rs || o_lcd_rw !== v.rnw) bad_bus++;
        if (!v.rnw && lcd_data !== v.wdata) bad_bus++;
      end else if (o_lcd_rs !== 1'b0 || o_lcd_rw !== 1'b1) begin
        bad_bus++;
      end
      if (o_busy !== 1'b1) bad_bus++;
      if (o_done) seen_done = 1'b1;
      else begin
        if (o_timeout !== 1'b0) bad_bus++;
        s++;
      end
    end

    e = sb.pop_front();
    check("done_seen", seen_done, 1'b1);
    check("done_latency", s + 1, e.exp_lat);
    check("en_pulse_count", pulses, e.exp_pulses);
    check("en_pattern_errors", bad_en, 0);
    check("en_length_errors", bad_len, 0);
    check("bus_phase_errors", bad_bus, 0);
    check("timeout_at_done", o_timeout, e.exp_timeout);
    check("rdata_at_done", o_rdata, e.exp_rdata);
    @(negedge clk);
    check("idle_after_done", {o_busy, o_done, o_lcd_en, o_lcd_rw}, 4'b0001);
  endtask

  initial begin
    int  edge_n;
    int  pulses;
    int  dones;
    int  idle_cnt;
    int  done_cnt;
    bit  en_prev;
    vec_t rv;

    //            rs    rnw   wdata  busy  emu    lat  pulses  tmo   rdata
    vecs[0] = '{1'b0, 1'b0, 8'h38,    0, 8'h00,  33,   2,  1'b0, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 8'h41,    3, 8'h00,  93,   5,  1'b0, 8'h00};
    vecs[2] = '{1'b1, 1'b1, 8'h00,    0, 8'h5A,  33,   2,  1'b0, 8'h5A};
    vecs[3] = '{1'b0, 1'b0, 8'h01, 1000, 8'h00, 113,   6,  1'b1, 8'h5A};

    // Reset state.
    #2;
    check("rst_rdata", o_rdata, 8'h00);
    check("rst_done", o_done, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_timeout", o_timeout, 1'b0);
    check("rst_lcd_rs", o_lcd_rs, 1'b0);
    check("rst_lcd_rw", o_lcd_rw, 1'b1);
    check("rst_lcd_en", o_lcd_en, 1'b0);
    check("rst_lcd_on", o_lcd_on, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("lcd_on_before_edge", o_lcd_on, 1'b0);
    @(posedge clk);
    #1 check("lcd_on_after_edge", o_lcd_on, 1'b1);

    for (int i = 0; i < 4; i++) run_txn(vecs[i]);
    check("timeout_holds_in_idle", o_timeout, 1'b1);

    // Start held high across three writes: one IDLE cycle between transactions.
    @(negedge clk);
    emu_busy_polls = 0;
    polls_done     = 0;
    i_rs = 1'b0; i_rnw = 1'b0; i_wdata = 8'h0C;
    i_start = 1'b1;
    done_at.push_back(33);
    done_at.push_back(67);
    done_at.push_back(101);
    edge_n = 0; pulses = 0; dones = 0; idle_cnt = 0; en_prev = 1'b0;
    for (int k = 0; k < 140; k++) begin
      @(posedge clk);
      edge_n++;
      @(negedge clk);
      if (edge_n == 1) check("timeout_cleared_by_start", o_timeout, 1'b0);
      if (o_lcd_en && !en_prev) pulses++;
      en_prev = o_lcd_en;
      if (!o_busy) idle_cnt++;
      if (o_done) begin
        dones++;
        if (done_at.size() > 0) check("b2b_done_edge", edge_n, done_at.pop_front());
        else check("b2b_extra_done", 1'b1, 1'b0);
        if (dones == 3) i_start = 1'b0;
      end
    end
    check("b2b_done_count", dones, 3);
    check("b2b_en_pulses", pulses, 6);
    check("b2b_idle_cycles", idle_cnt, 41);

    // Reset in the middle of an enable pulse.
    @(negedge clk);
    i_rs = 1'b0; i_rnw = 1'b0; i_wdata = 8'hA5;
    i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_en_high", o_lcd_en, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_en", o_lcd_en, 1'b0);
    check("mid_rst_rw", o_lcd_rw, 1'b1);
    check("mid_rst_busy", o_busy, 1'b0);
    check("mid_rst_lcd_on", o_lcd_on, 1'b0);
    check("mid_rst_bus_released", lcd_data == 8'hA5, 1'b0);
    done_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_done) done_cnt++;
    end
    check("mid_rst_no_done", done_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("lcd_on_after_rerelease", o_lcd_on, 1'b1);
    rv = '{1'b0, 1'b0, 8'hA5, 0, 8'h00, 33, 2, 1'b0, 8'h00};
    run_txn(rv);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
